// File: rtl/wb_memtest_master_if.sv
// Pipelined Wishbone bus bundle: 32-bit data, byte address, 4 byte selects,
// with stall for pipelined flow control.
interface if_wb #(
  parameter int AWIDTH = 26
) ();
  logic [AWIDTH-1:0] adr;
  logic [31:0]       dat_o;
  logic [31:0]       dat_i;
  logic              we;
  logic [3:0]        sel;
  logic              cyc;
  logic              stb;
  logic              ack;
  logic              stall;

  modport master (
    output adr, dat_o, we, sel, cyc, stb,
    input  dat_i, ack, stall
  );

  modport slave (
    input  adr, dat_o, we, sel, cyc, stb,
    output dat_i, ack, stall
  );
endinterface

// File: rtl/wb_memtest_master.sv
// Self-checking memory test master: one pipelined write cycle of an additive
// pseudo-random pattern, one idle cycle, then a pipelined read-back and compare.
module wb_memtest_master #(
  parameter int          AWIDTH = 26,
  parameter int          CWIDTH = 16,
  parameter int          TWIDTH = 12,
  parameter logic [31:0] STEP   = 32'h9E3779B9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  if_wb.master              bus,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_adr,
  input  logic [CWIDTH-1:0] word_count,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CWIDTH-1:0] err_count,
  output logic [AWIDTH-1:0] first_err_adr
);
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_GAP, S_READ, S_DONE} state_t;

  localparam logic [AWIDTH-1:0] ADR_MASK = {{(AWIDTH-2){1'b1}}, 2'b00};
  localparam logic [AWIDTH-1:0] ADR_INC  = AWIDTH'(4);
  localparam logic [CWIDTH-1:0] ONE_C    = CWIDTH'(1);
  localparam logic [TWIDTH-1:0] ONE_T    = TWIDTH'(1);

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] adr_q, base_q, chk_adr_q;
  logic [31:0]       dat_q, seed_q, chk_pat_q;
  logic [CWIDTH-1:0] wc_q, issued_q, acked_q, outstanding;
  logic [TWIDTH-1:0] tmo_q;
  logic              cyc, stb, we, accept, ack_ok, last_ack, tmo_hit;
  logic [3:0]        sel;

  function automatic logic [CWIDTH-1:0] sat_inc(input logic [CWIDTH-1:0] v);
    return (v == '1) ? v : v + ONE_C;
  endfunction

  assign outstanding = issued_q - acked_q;
  assign ack_ok      = bus.ack && (outstanding != '0);
  assign last_ack    = ack_ok && ((acked_q + ONE_C) == wc_q);
  assign tmo_hit     = (tmo_q == '1);

  assign bus.adr   = adr_q;
  assign bus.dat_o = dat_q;
  assign bus.cyc   = cyc;
  assign bus.stb   = stb;
  assign bus.we    = we;
  assign bus.sel   = sel;

  always_comb begin
    state_d = state_q;
    cyc     = 1'b0;
    stb     = 1'b0;
    we      = 1'b0;
    sel     = 4'h0;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (word_count != '0) ? S_WRITE : S_DONE;
      end
      S_WRITE, S_READ: begin
        cyc    = 1'b1;
        we     = (state_q == S_WRITE);
        sel    = 4'hf;
        stb    = (issued_q != wc_q);
        accept = stb && !bus.stall;
        if (last_ack)
          state_d = (state_q == S_WRITE) ? S_GAP : S_DONE;
        else if (!ack_ok && (outstanding != '0) && tmo_hit)
          state_d = S_DONE;
      end
      S_GAP:   state_d = S_READ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      adr_q         <= '0;
      dat_q         <= '0;
      base_q        <= '0;
      seed_q        <= '0;
      wc_q          <= '0;
      issued_q      <= '0;
      acked_q       <= '0;
      tmo_q         <= '0;
      chk_pat_q     <= '0;
      chk_adr_q     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      err_count     <= '0;
      first_err_adr <= '0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == S_DONE);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q        <= base_adr & ADR_MASK;
            adr_q         <= base_adr & ADR_MASK;
            seed_q        <= seed;
            dat_q         <= seed;
            wc_q          <= word_count;
            issued_q      <= '0;
            acked_q       <= '0;
            tmo_q         <= '0;
            err_count     <= '0;
            first_err_adr <= '0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            busy          <= 1'b1;
          end
        end
        S_WRITE, S_READ: begin
          // issue side: address/data only move when the slave takes the request
          if (accept) begin
            issued_q <= issued_q + ONE_C;
            adr_q    <= adr_q + ADR_INC;
            dat_q    <= dat_q + STEP;
          end
          // response side: acks retire requests and feed the checker
          if (ack_ok) begin
            acked_q <= acked_q + ONE_C;
            tmo_q   <= '0;
            if (state_q == S_READ) begin
              chk_pat_q <= chk_pat_q + STEP;
              chk_adr_q <= chk_adr_q + ADR_INC;
              if (bus.dat_i != chk_pat_q) begin
                err_count <= sat_inc(err_count);
                if (err_count == '0) first_err_adr <= chk_adr_q;
              end
            end
          end else if (outstanding != '0) begin
            if (tmo_hit) timeout <= 1'b1;
            else         tmo_q   <= tmo_q + ONE_T;
          end
        end
        S_GAP: begin
          adr_q     <= base_q;
          dat_q     <= seed_q;
          chk_adr_q <= base_q;
          chk_pat_q <= seed_q;
          issued_q  <= '0;
          acked_q   <= '0;
          tmo_q     <= '0;
        end
        S_DONE: begin
          busy <= 1'b0;
          pass <= (err_count == '0) && !timeout;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_memtest_master.sv
// Bench for wb_memtest_master: pipelined RAM slave model with optional stall,
// read corruption and ack suppression; request scoreboard plus result checks.
module tb_wb_memtest_master;
  localparam int          AW   = 26;
  localparam int          CW   = 16;
  localparam int          TW   = 12;
  localparam logic [31:0] STEP = 32'h9E3779B9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start;
  logic [AW-1:0] base_adr;
  logic [CW-1:0] word_count;
  logic [31:0]   seed;
  logic          busy, done, pass, timeout;
  logic [CW-1:0] err_count;
  logic [AW-1:0] first_err_adr;

  if_wb #(.AWIDTH(AW)) wb ();

  wb_memtest_master #(.AWIDTH(AW), .CWIDTH(CW), .TWIDTH(TW), .STEP(STEP)) dut (
    .clk_i(clk), .rst_i(rst), .bus(wb), .start(start), .base_adr(base_adr),
    .word_count(word_count), .seed(seed), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_count(err_count), .first_err_adr(first_err_adr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  typedef struct {
    logic [AW-1:0] adr;
    logic          we;
    logic [31:0]   dat;
  } req_t;
  req_t exp_q[$];

  // slave model controls
  bit          stall_mode   = 1'b0;
  bit          corrupt_mode = 1'b0;
  int          ack_limit    = 1 << 30;
  int          rd_base      = 0;
  int          wr_acc       = 0;
  int          rd_acc       = 0;
  logic [31:0] mem [0:255];

  always @(posedge clk) begin
    if (rst) begin
      wb.ack   <= 1'b0;
      wb.stall <= 1'b0;
      wb.dat_i <= 32'h0;
    end else begin
      wb.ack   <= 1'b0;
      wb.stall <= stall_mode ? !wb.stall : 1'b0;
      if (wb.cyc && wb.stb && !wb.stall) begin
        if (wb.we) begin
          mem[wb.adr[9:2]] <= wb.dat_o;
          wr_acc <= wr_acc + 1;
          wb.ack <= 1'b1;
        end else begin
          wb.dat_i <= mem[wb.adr[9:2]] ^
                      ((corrupt_mode && ((rd_acc - rd_base) == 2 || (rd_acc - rd_base) == 5)) ? 32'h1 : 32'h0);
          wb.ack <= ((rd_acc - rd_base) < ack_limit);
          rd_acc <= rd_acc + 1;
        end
      end
    end
  end

  // request monitor: scoreboard pop on accept, stability check while stalled
  logic [AW-1:0] hold_adr;
  logic [31:0]   hold_dat;
  bit            hold_vld = 1'b0;
  req_t          e;

  always @(negedge clk) begin
    if (rst) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld && wb.stb) begin
        check("stall_hold_adr", 64'(wb.adr), 64'(hold_adr));
        check("stall_hold_dat", 64'(wb.dat_o), 64'(hold_dat));
      end
      hold_vld = wb.cyc && wb.stb && wb.stall;
      hold_adr = wb.adr;
      hold_dat = wb.dat_o;
      if (wb.cyc && wb.stb && !wb.stall) begin
        check("req_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("req_adr", 64'(wb.adr), 64'(e.adr));
          check("req_we", 64'(wb.we), 64'(e.we));
          check("req_sel", 64'(wb.sel), 64'hf);
          if (e.we) check("req_dat", 64'(wb.dat_o), 64'(e.dat));
        end
      end
    end
  end

  task automatic push_expect(input logic [AW-1:0] b, input int n, input logic [31:0] sd);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = (b & ~AW'(3)) + AW'(4 * i);
      exp_q.push_back('{adr: a, we: 1'b1, dat: sd + 32'(i) * STEP});
    end
    for (int i = 0; i < n; i++) begin
      a = (b & ~AW'(3)) + AW'(4 * i);
      exp_q.push_back('{adr: a, we: 1'b0, dat: 32'h0});
    end
  endtask

  task automatic run_test(input string tag, input logic [AW-1:0] b, input int n,
                          input logic [31:0] sd, input int budget, input int poke,
                          output int cycles, output bit cyc_seen);
    int wr0;
    push_expect(b, n, sd);
    wr0        = wr_acc;
    rd_base    = rd_acc;
    base_adr   = b;
    word_count = CW'(n);
    seed       = sd;
    start      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    cycles   = 1;
    cyc_seen = wb.cyc;
    while (!done && cycles < budget) begin
      @(negedge clk);
      cycles++;
      cyc_seen = cyc_seen | wb.cyc;
      start = (cycles == poke);
    end
    start = 1'b0;
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_writes"}, 64'(wr_acc - wr0), 64'(n));
    check({tag, "_reads"}, 64'(rd_acc - rd_base), 64'(n));
  endtask

  task automatic tail(input string tag);
    int extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) extra++;
    end
    check({tag, "_extra_done"}, 64'(extra), 64'd0);
    check({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_cyc_after"}, 64'(wb.cyc), 64'd0);
  endtask

  int cyc_n;
  bit seen;

  initial begin
    start = 1'b0; base_adr = '0; word_count = '0; seed = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pass", 64'(pass), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    check("rst_first_err", 64'(first_err_adr), 64'd0);
    check("rst_cyc", 64'(wb.cyc), 64'd0);
    check("rst_stb", 64'(wb.stb), 64'd0);
    check("rst_we", 64'(wb.we), 64'd0);
    check("rst_sel", 64'(wb.sel), 64'd0);
    check("rst_adr", 64'(wb.adr), 64'd0);
    check("rst_dat", 64'(wb.dat_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // zero-wait RAM, known pattern
    run_test("basic", AW'('h100), 4, 32'h0, 100, -1, cyc_n, seen);
    check("basic_latency", 64'(cyc_n), 64'd13);
    check("basic_pass", 64'(pass), 64'd1);
    check("basic_err", 64'(err_count), 64'd0);
    check("basic_timeout", 64'(timeout), 64'd0);
    tail("basic");

    // alternate-cycle stall
    stall_mode = 1'b1;
    run_test("stall", AW'('h40), 8, 32'hCAFEF00D, 300, -1, cyc_n, seen);
    check("stall_pass", 64'(pass), 64'd1);
    check("stall_err", 64'(err_count), 64'd0);
    stall_mode = 1'b0;
    tail("stall");

    // words 2 and 5 read back with bit 0 flipped
    corrupt_mode = 1'b1;
    run_test("corrupt", AW'('h0), 8, 32'h12345678, 100, -1, cyc_n, seen);
    check("corrupt_err", 64'(err_count), 64'd2);
    check("corrupt_first", 64'(first_err_adr), 64'h8);
    check("corrupt_pass", 64'(pass), 64'd0);
    check("corrupt_timeout", 64'(timeout), 64'd0);
    corrupt_mode = 1'b0;
    tail("corrupt");

    // slave acks only 3 of 4 reads
    ack_limit = 3;
    run_test("tmo", AW'('h80), 4, 32'h1, 6000, -1, cyc_n, seen);
    check("tmo_flag", 64'(timeout), 64'd1);
    check("tmo_pass", 64'(pass), 64'd0);
    check("tmo_wait_window", 64'(cyc_n >= 4105 && cyc_n <= 4112), 64'd1);
    ack_limit = 1 << 30;
    tail("tmo");

    // empty range
    run_test("zero", AW'('h0), 0, 32'h0, 20, -1, cyc_n, seen);
    check("zero_latency", 64'(cyc_n), 64'd2);
    check("zero_pass", 64'(pass), 64'd1);
    check("zero_cyc_seen", 64'(seen), 64'd0);
    tail("zero");

    // start pulsed while busy must be ignored
    run_test("restart", AW'('h100), 4, 32'hA5A5A5A5, 100, 5, cyc_n, seen);
    check("restart_latency", 64'(cyc_n), 64'd13);
    check("restart_pass", 64'(pass), 64'd1);
    tail("restart");

    // asynchronous reset in the middle of the read phase
    push_expect(AW'('h200), 8, 32'h0BADBEEF);
    rd_base = rd_acc; base_adr = AW'('h200); word_count = CW'(8); seed = 32'h0BADBEEF;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    check("arst_in_read", 64'(wb.cyc && !wb.we), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_cyc", 64'(wb.cyc), 64'd0);
    check("arst_stb", 64'(wb.stb), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_test("post_rst", AW'('h100), 4, 32'h55, 100, -1, cyc_n, seen);
    check("post_rst_latency", 64'(cyc_n), 64'd13);
    check("post_rst_pass", 64'(pass), 64'd1);
    tail("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_memtest_master.md
Name: wb_memtest_master

Overview:
- Pipelined Wishbone master that drives the slave port of the SDRAM controller (or any pipelined WB slave) with a self-checking memory test.
- On start it writes a deterministic pseudo-random pattern over a word range as one pipelined cycle, drops cyc, then reads the range back in a second pipelined cycle and checks every word.
- Reports pass/fail, error count, first failing address and timeout status.

Parameters:
- AWIDTH, 26, byte address width of bus.adr.
- CWIDTH, 16, width of the word-count and error-count fields.
- TWIDTH, 12, ack-timeout counter width; timeout fires after 2^TWIDTH-1 ack-less cycles.
- STEP, 32'h9E3779B9, additive pattern increment.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  asynchronous, active-high reset.
- bus  if_wb.master  -  pipelined Wishbone master port: adr, dat_o (write data), dat_i (read data), we, sel, cyc, stb, ack, stall.
- start  input  1  one-cycle request; sampled only while busy=0.
- base_adr  input  AWIDTH  first byte address; bits [1:0] are ignored and driven as 0.
- word_count  input  CWIDTH  number of 32-bit words to test.
- seed  input  32  pattern for word 0.
- busy  output  1  test in progress.
- done  output  1  one-cycle pulse at test end.
- pass  output  1  valid from done until the next start.
- timeout  output  1  test aborted on an ack timeout.
- err_count  output  CWIDTH  count of read mismatches; saturates at all-ones.
- first_err_adr  output  AWIDTH  byte address of the first mismatch.

Behaviour:
- Reset values: all outputs 0; bus.cyc, stb, we, sel, adr and dat_o are 0; state is S_IDLE.
- Reset is asynchronous. Reset mid-test drops cyc and stb immediately, with no completion pulse.
- Pattern:
  - pat(0) = seed; pat(i+1) = pat(i) + STEP, mod 2^32.
  - Separate accumulators are kept for issue and check.
  - adr(i) = {base_adr[AWIDTH-1:2], 2'b00} + 4*i, wrapping mod 2^AWIDTH.
- States:
  - S_IDLE: on start, latch base_adr/word_count/seed, clear err_count, first_err_adr, pass and timeout, and set busy. Go to S_WRITE if word_count != 0, else S_DONE.
  - S_WRITE: assert cyc=1, we=1, sel=4'hf.
    - stb=1 while issued < word_count.
    - A request is accepted on a cycle with stb & !stall; on acceptance, advance adr, dat_o and issued.
    - Drive adr and dat_o stably while stalled.
    - Count acks. When acks == word_count, go to S_GAP.
  - S_GAP: exactly one cycle with cyc=0 and stb=0, then S_READ.
  - S_READ: assert cyc=1, we=0, sel=4'hf; issue the same sequence as S_WRITE.
    - On each ack, compare bus.dat_i with the check pattern and advance the check accumulator.
    - On a mismatch, increment err_count (saturating). If err_count was 0, capture adr(check index).
    - When acks == word_count, go to S_DONE.
  - S_DONE: cyc=0, stb=0, busy=0, done=1 for this one cycle; pass = (err_count==0 && !timeout). Then S_IDLE.
- Acks:
  - An ack may arrive in the same cycle as a new request acceptance.
  - Acks arriving while outstanding == 0 are ignored.
  - An ack and a stall in the same cycle are independent.
- Timeout:
  - The counter resets on every ack and on entering S_WRITE or S_READ.
  - It increments on each cycle in those states with outstanding > 0.
  - At all-ones: set timeout and go to S_DONE (pass=0). Remaining outstanding acks are abandoned.
- Latency:
  - start at edge t → cyc/stb high in cycle t+1.
  - With a zero-wait slave (no stall, ack 1 cycle after accept), one test takes 2*(N+1)+3 cycles from start to done.
- start while busy is ignored.
- Exactly one done pulse per accepted start.

Test Plan:
- Zero-latency RAM model, base 0x100, N=4, seed 32'h0: write data 0, 9E3779B9, 3C6EF372, DAA66D2B to 0x100..0x10C; then read back. Required: done, pass=1, err_count=0; start-to-done = 13 cycles.
- Slave asserting stall on alternate cycles, N=8: adr/dat_o held stable during stall; exactly 8 writes and 8 reads accepted; pass=1.
- Model corrupts the reads of words 2 and 5 (bit 0 flipped), base 0x0: err_count=2, first_err_adr=0x8, pass=0.
- Slave stops acking after 3 of 4 read requests: timeout=1 after 4095 idle cycles; done pulses once; pass=0; cyc=0 afterwards.
- word_count=0: done in cycle t+2, pass=1, cyc never asserted. A start pulsed during a running test is ignored.
- rst_i asserted mid-S_READ: cyc, stb, busy and done go to 0 asynchronously; a subsequent start runs a clean test with pass=1.
